// File: rtl/pl_mem_arb_if.sv
// Signal bundle joining the IF/MEM pipeline stages, the arbiter and the unified memory.
// The arbiter uses the slave modport; the pipeline/memory side uses master.
interface pl_mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_inst;
  logic          if_ack;
  logic          if_stall;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          bus_err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_inst, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_inst, if_ack, if_stall, d_rdata, d_ack, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/pl_mem_arb.sv
// IF/MEM arbiter for a single-port unified memory, with MEM-run fairness and a timeout watchdog.
// Define PL_MEM_ARB_IBUF_EN to add a one-entry instruction buffer that short-circuits repeat fetches.
module pl_mem_arb #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic        clock,
  input  logic        resetn,
  pl_mem_arb_if.slave bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_I   = 2'd1;
  localparam logic [1:0] BUSY_D   = 2'd2;
  localparam logic [3:0] RUN_MAX  = 4'(MAX_D_RUN);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic [DW-1:0] if_inst_q, if_inst_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          bus_err_q, bus_err_d;
  logic [3:0]    run_q, run_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          busy, eff_if, eff_d, grant_d, grant_i, done_ok, done_tmo, ibuf_hit;
  logic [DW-1:0] ibuf_data;

`ifdef PL_MEM_ARB_IBUF_EN
  logic          ibuf_vld_q, ibuf_vld_d;
  logic [AW-1:0] ibuf_addr_q, ibuf_addr_d;
  logic [DW-1:0] ibuf_inst_q, ibuf_inst_d;
`endif

  // A requester whose ack is showing this cycle is still holding the old request; mask it.
  always_comb begin
    busy     = (state_q == BUSY_I) || (state_q == BUSY_D);
    eff_if   = bus.if_req & ~if_ack_q;
    eff_d    = bus.d_req & ~d_ack_q;
    grant_d  = (state_q == IDLE) && eff_d && !(eff_if && (run_q == RUN_MAX));
    grant_i  = (state_q == IDLE) && eff_if && !grant_d;
    done_ok  = busy && bus.mem_ack;
    done_tmo = busy && !bus.mem_ack && (tmo_q == TMO_LAST);
`ifdef PL_MEM_ARB_IBUF_EN
    ibuf_hit  = ibuf_vld_q && (ibuf_addr_q == bus.if_addr);
    ibuf_data = ibuf_inst_q;
`else
    ibuf_hit  = 1'b0;
    ibuf_data = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    if_inst_d   = if_inst_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    bus_err_d   = bus_err_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    if (grant_d) begin
      state_d     = BUSY_D;
      mem_req_d   = 1'b1;
      mem_we_d    = bus.d_we;
      mem_addr_d  = bus.d_addr;
      mem_wdata_d = bus.d_wdata;
      tmo_d       = '0;
      if (bus.if_req && (run_q != RUN_MAX)) run_d = run_q + 4'd1;
    end else if (grant_i) begin
      run_d = '0;
      if (ibuf_hit) begin
        if_ack_d  = 1'b1;
        if_inst_d = ibuf_data;
      end else begin
        state_d    = BUSY_I;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = bus.if_addr;
        tmo_d      = '0;
      end
    end else if (done_ok || done_tmo) begin
      // A watchdog abort still pulses the ack so the stalled stage can move on.
      state_d   = IDLE;
      mem_req_d = 1'b0;
      if (done_tmo) bus_err_d = 1'b1;
      if (state_q == BUSY_I) begin
        if_ack_d  = 1'b1;
        if_inst_d = done_ok ? bus.mem_rdata : '0;
      end else begin
        d_ack_d   = 1'b1;
        d_rdata_d = done_ok ? bus.mem_rdata : '0;
      end
    end else if (busy) begin
      tmo_d = tmo_q + 8'd1;
    end else if (state_q != IDLE) begin
      state_d   = IDLE;
      mem_req_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      if_inst_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      bus_err_q   <= 1'b0;
      run_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      if_inst_q   <= if_inst_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      bus_err_q   <= bus_err_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
    end
  end

`ifdef PL_MEM_ARB_IBUF_EN
  // Any store may hit code, so a store grant invalidates the buffered instruction.
  always_comb begin
    ibuf_vld_d  = ibuf_vld_q;
    ibuf_addr_d = ibuf_addr_q;
    ibuf_inst_d = ibuf_inst_q;
    if (grant_d && bus.d_we) ibuf_vld_d = 1'b0;
    if (done_ok && (state_q == BUSY_I)) begin
      ibuf_vld_d  = 1'b1;
      ibuf_addr_d = mem_addr_q;
      ibuf_inst_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) ibuf_vld_q <= 1'b0;
    else         ibuf_vld_q <= ibuf_vld_d;
  end

  always_ff @(posedge clock) begin
    ibuf_addr_q <= ibuf_addr_d;
    ibuf_inst_q <= ibuf_inst_d;
  end
`endif

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_inst   = if_inst_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.if_stall  = bus.if_req & ~if_ack_q;
  assign bus.d_stall   = bus.d_req & ~d_ack_q;
endmodule
